instr_encoder: RTL and testbench
================================

# instr_encoder

Streaming instruction encoder that packs decoded instruction fields (8-bit canonical opcode, Rdest, Rsrc, immediate) into 16-bit machine words in exactly the format the CPU's instruction decoder consumes. It writes them to instruction memory through a valid/ready write port with an auto-incrementing address. It sits between the test/boot program source (host loader or bench) and the instruction memory, and is the writer side of the decoder's instruction format.

## Interface
- ADDR_W, 10: instruction memory address width (words).
- FIFO_DEPTH, 4: encoded-word buffer depth; power of two, ≥2.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  pulse: begin a load session at start_addr (honoured in IDLE/END only).
- start_addr  in  ADDR_W  first write address of session.
- in_valid  in  1  field bundle valid.
- in_ready  out  1  encoder accepts bundle this cycle.
- in_op  in  8  canonical opcode {major[3:0], ext[3:0]}.
- in_rdest  in  4  destination/first register.
- in_rsrc  in  4  source register.
- in_imm  in  16  signed immediate.
- mem_valid  out  1  write request valid.
- mem_ready  in  1  memory accepts write.
- mem_addr  out  ADDR_W  write address.
- mem_wdata  out  16  encoded instruction.
- err  out  1  one-cycle pulse: accepted bundle rejected.
- err_code  out  2  01 illegal opcode, 10 immediate out of range; held until next err.
- err_count  out  8  saturating count of rejected bundles since reset.
- busy  out  1  state RUN.
- done  out  1  state END.

## Operation
- Format selected from in_op[7:4] (major):
  - 0001,0010,0011,0101,0110,0111,1001,1010,1011,1100 → 8-bit immediate: word = {major, rdest, imm[7:0]}; in_op[3:0] ignored.
  - 1000 with in_op[3:1] ∈ {000,001,100,101} → shift immediate: word = {1000, rdest, op[3:1], imm[4:0]}; op[0] ignored.
  - 1000 with op[3:2]=01, major 0000, major 0100 → register: word = {major, rdest, op[3:0], rsrc}.
  - 1000 with op[3:1]=11x, majors 1101/1110/1111 → illegal, always rejected (err_code 01).
- Rejected bundles are still handshaken (consumed), produce err, increment err_count (saturate at 255), consume no FIFO slot and no address.
- States: IDLE (reset) -start→ RUN; RUN -all addresses reserved and FIFO drained→ END; END -start→ RUN. start in RUN ignored.
- On start: write address and reserve counter load start_addr; err_count unchanged.
- Reserve counter (ADDR_W+1 bits) increments per accepted legal word; when it reaches 2^ADDR_W, in_ready drops for the rest of the session (no wrap-around write to address 0).
- in_ready = RUN && FIFO not full && reserve < 2^ADDR_W; computed from registered state only (a same-cycle pop does not enable a push into a full FIFO).
- Write address increments by 1 per mem_valid && mem_ready transfer.

## Timing
- Reset: state IDLE, in_ready 0, mem_valid 0, mem_addr 0, mem_wdata 0, err 0, err_code 00, err_count 0, busy 0, done 0, FIFO empty.
- Bundle accepted at edge N is at the FIFO head no earlier than cycle N+1 (mem_valid high in N+1 if FIFO was empty). Throughput 1 word/cycle with mem_ready held high.
- err asserts in cycle N+1 for a bundle rejected at edge N.
- mem_valid/mem_addr/mem_wdata stable while mem_valid && !mem_ready.
- Simultaneous push and pop: count unchanged; both occur.
- reset mid-session: FIFO contents discarded, in-flight write dropped, state IDLE next cycle.
- done asserts the cycle after the last write transfer of a session that exhausted the address space.

## Configuration
- INSTR_ENCODER_IMM_CHECK_EN defined: 8-bit form requires in_imm ∈ [-128,127], shift form requires in_imm ∈ [-16,15] (upper bits equal sign bit); violation → reject, err_code 10.
- Undefined: immediates silently truncated to imm[7:0] / imm[4:0]; only illegal-opcode rejection remains.

## Test plan
- Reset, start with start_addr=0x010; send ADD (op 0x05, rdest 1, rsrc 2) → mem_addr 0x010, mem_wdata 0x0152.
- ADDI op 0x50, rdest 3, imm -1 → 0x53FF; LSHI op 0x80, rdest 2, imm 5 → 0x8205; ARSHI op 0x8A, rdest 4, imm -16 → 0x84B0; LOAD op 0x40, rdest 1, rsrc 7 → 0x4107.
- op 0xD0 → err pulse, err_code 01, err_count 1, no write; with macro, ADDI imm 200 → err_code 10; without macro, ADDI imm 200 → 0x5xC8 written.
- mem_ready low 8 cycles while streaming 6 legal bundles → in_ready drops after FIFO_DEPTH(4) accepts; outputs stable; all 6 written in order at consecutive addresses once released.
- ADDR_W=4, start_addr=0xE, 3 bundles → writes 0xE, 0xF; third bundle not accepted; done after last write; start again resumes at new start_addr.
- reset asserted with 3 words queued → mem_valid 0 next cycle, IDLE, no further writes.

Source files
------------

// File: rtl/instr_encoder.sv
// Streaming encoder: packs decoded instruction fields into 16-bit words and writes them to
// instruction memory. Define INSTR_ENCODER_IMM_CHECK_EN to reject out-of-range immediates.
module instr_encoder #(
    parameter int ADDR_W     = 10,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] start_addr_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [7:0]        in_op_i,
    input  logic [3:0]        in_rdest_i,
    input  logic [3:0]        in_rsrc_i,
    input  logic [15:0]       in_imm_i,
    output logic              mem_valid_o,
    input  logic              mem_ready_i,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [15:0]       mem_wdata_o,
    output logic              err_o,
    output logic [1:0]        err_code_o,
    output logic [7:0]        err_count_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_END  = 2'd2;

`ifdef INSTR_ENCODER_IMM_CHECK_EN
    localparam logic IMM_CHECK = 1'b1;
`else
    localparam logic IMM_CHECK = 1'b0;
`endif

    logic [1:0]        state_q, state_d;
    logic [ADDR_W:0]   reserve_q, reserve_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [PTR_W-1:0]  wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0]  rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              err_q, err_d;
    logic [1:0]        errCode_q, errCode_d;
    logic [7:0]        errCount_q, errCount_d;
    logic [15:0]       fifoMem_q [FIFO_DEPTH];

    logic [3:0]  major;
    logic [3:0]  ext;
    logic        immFits8;
    logic        immFits5;
    logic        illegalOp;
    logic        immBad;
    logic [15:0] encWord;
    logic        fifoFull;
    logic        accept;
    logic        reject;
    logic        push;
    logic        pop;

    assign major    = in_op_i[7:4];
    assign ext      = in_op_i[3:0];
    assign immFits8 = (&in_imm_i[15:7]) | ~(|in_imm_i[15:7]);
    assign immFits5 = (&in_imm_i[15:4]) | ~(|in_imm_i[15:4]);

    // Major opcode picks the word layout; ext only matters for major 1000.
    always_comb begin
        encWord   = 16'h0000;
        illegalOp = 1'b0;
        immBad    = 1'b0;
        case (major)
            4'h0, 4'h4: encWord = {major, in_rdest_i, ext, in_rsrc_i};
            4'h8: begin
                if (ext[3:2] == 2'b01) begin
                    encWord = {major, in_rdest_i, ext, in_rsrc_i};
                end else if (ext[3:2] == 2'b11) begin
                    illegalOp = 1'b1;
                end else begin
                    encWord = {major, in_rdest_i, ext[3:1], in_imm_i[4:0]};
                    immBad  = IMM_CHECK && !immFits5;
                end
            end
            4'hD, 4'hE, 4'hF: illegalOp = 1'b1;
            default: begin
                encWord = {major, in_rdest_i, in_imm_i[7:0]};
                immBad  = IMM_CHECK && !immFits8;
            end
        endcase
    end

    assign fifoFull    = (count_q == CNT_W'(FIFO_DEPTH));
    assign in_ready_o  = (state_q == ST_RUN) && !fifoFull && !reserve_q[ADDR_W];
    assign accept      = in_valid_i && in_ready_o;
    assign reject      = illegalOp || immBad;
    assign push        = accept && !reject;
    assign mem_valid_o = (count_q != '0);
    assign pop         = mem_valid_o && mem_ready_i;

    always_comb begin
        state_d    = state_q;
        reserve_d  = reserve_q;
        waddr_d    = waddr_q;
        wrPtr_d    = wrPtr_q;
        rdPtr_d    = rdPtr_q;
        count_d    = count_q;
        err_d      = 1'b0;
        errCode_d  = errCode_q;
        errCount_d = errCount_q;

        if (push) begin
            wrPtr_d   = wrPtr_q + 1'b1;
            reserve_d = reserve_q + 1'b1;
        end
        if (pop) begin
            rdPtr_d = rdPtr_q + 1'b1;
            waddr_d = waddr_q + 1'b1;
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end

        if (accept && reject) begin
            err_d     = 1'b1;
            errCode_d = illegalOp ? 2'b01 : 2'b10;
            if (errCount_q != 8'hFF) begin
                errCount_d = errCount_q + 8'd1;
            end
        end

        // END is entered on the edge of the final write so done follows it directly.
        case (state_q)
            ST_IDLE, ST_END: begin
                if (start_i) begin
                    state_d   = ST_RUN;
                    reserve_d = {1'b0, start_addr_i};
                    waddr_d   = start_addr_i;
                end
            end
            ST_RUN: begin
                if (reserve_d[ADDR_W] && (count_d == '0)) begin
                    state_d = ST_END;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= ST_IDLE;
            reserve_q  <= '0;
            waddr_q    <= '0;
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            count_q    <= '0;
            err_q      <= 1'b0;
            errCode_q  <= 2'b00;
            errCount_q <= 8'h00;
        end else begin
            state_q    <= state_d;
            reserve_q  <= reserve_d;
            waddr_q    <= waddr_d;
            wrPtr_q    <= wrPtr_d;
            rdPtr_q    <= rdPtr_d;
            count_q    <= count_d;
            err_q      <= err_d;
            errCode_q  <= errCode_d;
            errCount_q <= errCount_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifoMem_q[i] <= 16'h0000;
            end
        end else if (push) begin
            fifoMem_q[wrPtr_q] <= encWord;
        end
    end

    assign mem_addr_o  = waddr_q;
    assign mem_wdata_o = fifoMem_q[rdPtr_q];
    assign err_o       = err_q;
    assign err_code_o  = errCode_q;
    assign err_count_o = errCount_q;
    assign busy_o      = (state_q == ST_RUN);
    assign done_o      = (state_q == ST_END);

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed steps plus random traffic, checked every cycle against
// a queue-based reference model built from the encoding and session rules.
module tb_instr_encoder;

    localparam int ADDR_W = 10;
    localparam int SPACE  = 1 << ADDR_W;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [ADDR_W-1:0] startAddr;
    logic              inValid;
    logic              inReady;
    logic [7:0]        inOp;
    logic [3:0]        inRdest;
    logic [3:0]        inRsrc;
    logic [15:0]       inImm;
    logic              memValid;
    logic              memReady;
    logic [ADDR_W-1:0] memAddr;
    logic [15:0]       memWdata;
    logic              err;
    logic [1:0]        errCode;
    logic [7:0]        errCount;
    logic              busy;
    logic              done;

    int compared   = 0;
    int mismatched = 0;

    bit          mRun;
    bit          mDone;
    int          mReserve;
    int          mAddr;
    logic [15:0] mQ[$];
    bit          mErr;
    int          mErrCode;
    int          mErrCount;
    bit          lastAccepted;

    instr_encoder #(.ADDR_W(ADDR_W), .FIFO_DEPTH(DEPTH)) dut (
        .clk_i(clk), .reset_i(reset), .start_i(start), .start_addr_i(startAddr),
        .in_valid_i(inValid), .in_ready_o(inReady), .in_op_i(inOp), .in_rdest_i(inRdest),
        .in_rsrc_i(inRsrc), .in_imm_i(inImm), .mem_valid_o(memValid), .mem_ready_i(memReady),
        .mem_addr_o(memAddr), .mem_wdata_o(memWdata), .err_o(err), .err_code_o(errCode),
        .err_count_o(errCount), .busy_o(busy), .done_o(done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "[TB] watchdog expired");
    end

    // verdict: 0 legal, 1 illegal opcode, 2 immediate out of range
    function automatic void refEncode(input logic [7:0] op, input logic [3:0] rd,
                                      input logic [3:0] rs, input logic [15:0] imm,
                                      output int verdict, output logic [15:0] word);
        int major = int'(op) / 16;
        int ext   = int'(op) % 16;
        int uimm  = int'(imm);
        verdict = 0;
        word    = 16'h0000;
        if (major inside {1, 2, 3, 5, 6, 7, 9, 10, 11, 12}) begin
            word = 16'(major * 4096 + int'(rd) * 256 + uimm % 256);
`ifdef INSTR_ENCODER_IMM_CHECK_EN
            if (int'($signed(imm)) < -128 || int'($signed(imm)) > 127) verdict = 2;
`endif
        end else if (major == 0 || major == 4 || (major == 8 && ext / 4 == 1)) begin
            word = 16'(major * 4096 + int'(rd) * 256 + ext * 16 + int'(rs));
        end else if (major == 8 && ((ext / 2) inside {0, 1, 4, 5})) begin
            word = 16'(8 * 4096 + int'(rd) * 256 + (ext / 2) * 32 + uimm % 32);
`ifdef INSTR_ENCODER_IMM_CHECK_EN
            if (int'($signed(imm)) < -16 || int'($signed(imm)) > 15) verdict = 2;
`endif
        end else begin
            verdict = 1;
        end
    endfunction

    function automatic void modelReset();
        mRun      = 1'b0;
        mDone     = 1'b0;
        mReserve  = 0;
        mAddr     = 0;
        mQ.delete();
        mErr      = 1'b0;
        mErrCode  = 0;
        mErrCount = 0;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [7:0] op, input logic [3:0] rd,
                                 input logic [3:0] rs, input logic [15:0] imm);
        inValid = v;
        inOp    = op;
        inRdest = rd;
        inRsrc  = rs;
        inImm   = imm;
    endtask

    // One clock: compare all outputs to the model, then advance the model across the edge.
    task automatic cycle();
        logic        expReady;
        int          verdict;
        logic [15:0] word;
        #1;
        expReady = mRun && (mQ.size() < DEPTH) && (mReserve < SPACE);
        checkOutput("in_ready", inReady, expReady);
        checkOutput("mem_valid", memValid, mQ.size() != 0);
        checkOutput("mem_addr", memAddr, mAddr);
        if (mQ.size() != 0) checkOutput("mem_wdata", memWdata, mQ[0]);
        checkOutput("err", err, mErr);
        checkOutput("err_code", errCode, mErrCode);
        checkOutput("err_count", errCount, mErrCount);
        checkOutput("busy", busy, mRun);
        checkOutput("done", done, mDone);
        lastAccepted = inValid && expReady;
        if (reset) begin
            modelReset();
        end else begin
            mErr = 1'b0;
            if (mQ.size() != 0 && memReady) begin
                void'(mQ.pop_front());
                mAddr = (mAddr + 1) % SPACE;
            end
            if (lastAccepted) begin
                refEncode(inOp, inRdest, inRsrc, inImm, verdict, word);
                if (verdict == 0) begin
                    mQ.push_back(word);
                    mReserve++;
                end else begin
                    mErr      = 1'b1;
                    mErrCode  = verdict;
                    mErrCount = (mErrCount < 255) ? mErrCount + 1 : 255;
                end
            end
            if (start && !mRun) begin
                mRun     = 1'b1;
                mDone    = 1'b0;
                mAddr    = int'(startAddr);
                mReserve = int'(startAddr);
            end
            if (mRun && mReserve == SPACE && mQ.size() == 0) begin
                mRun  = 1'b0;
                mDone = 1'b1;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic sendBundle(input logic [7:0] op, input logic [3:0] rd, input logic [3:0] rs,
                              input logic [15:0] imm);
        bit got = 1'b0;
        applyStimulus(1'b1, op, rd, rs, imm);
        for (int c = 0; c < 50 && !got; c++) begin
            cycle();
            got = lastAccepted;
        end
        checkOutput("acceptWithinBudget", got, 1);
        inValid = 1'b0;
    endtask

    task automatic expectWord(input string tag, input logic [15:0] word,
                              input logic [ADDR_W-1:0] addr);
        #1;
        checkOutput({tag, "_valid"}, memValid, 1);
        checkOutput({tag, "_data"}, memWdata, word);
        checkOutput({tag, "_addr"}, memAddr, addr);
    endtask

    task automatic drain();
        for (int c = 0; c < 40 && mQ.size() != 0; c++) cycle();
        #1;
        checkOutput("drained", memValid, 0);
    endtask

    initial begin
        int sent;
        reset     = 1'b1;
        start     = 1'b0;
        startAddr = '0;
        memReady  = 1'b0;
        applyStimulus(1'b0, 8'h00, 4'h0, 4'h0, 16'h0000);
        repeat (3) @(posedge clk);
        @(negedge clk);
        modelReset();
        reset = 1'b0;

        #1;
        checkOutput("rst_in_ready", inReady, 0);
        checkOutput("rst_mem_valid", memValid, 0);
        checkOutput("rst_mem_addr", memAddr, 0);
        checkOutput("rst_mem_wdata", memWdata, 0);
        checkOutput("rst_err_code", errCode, 0);
        checkOutput("rst_err_count", errCount, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);

        $display("[TB] directed encodings");
        startAddr = 10'h010;
        start     = 1'b1;
        cycle();
        start    = 1'b0;
        memReady = 1'b1;
        sendBundle(8'h05, 4'd1, 4'd2, 16'h0000);
        expectWord("ADD", 16'h0152, 10'h010);
        cycle();
        sendBundle(8'h50, 4'd3, 4'd0, 16'hFFFF);
        expectWord("ADDI", 16'h53FF, 10'h011);
        cycle();
        sendBundle(8'h80, 4'd2, 4'd0, 16'd5);
        expectWord("LSHI", 16'h8205, 10'h012);
        cycle();
        sendBundle(8'h8A, 4'd4, 4'd0, 16'hFFF0);
        expectWord("ARSHI", 16'h84B0, 10'h013);
        cycle();
        sendBundle(8'h40, 4'd1, 4'd7, 16'h0000);
        expectWord("LOAD", 16'h4107, 10'h014);
        cycle();

        sendBundle(8'hD0, 4'd1, 4'd1, 16'h0000);
        #1;
        checkOutput("illegal_err", err, 1);
        checkOutput("illegal_code", errCode, 2'b01);
        checkOutput("illegal_count", errCount, 1);
        checkOutput("illegal_nowrite", memValid, 0);
        cycle();

        sendBundle(8'h50, 4'd3, 4'd0, 16'd200);
`ifdef INSTR_ENCODER_IMM_CHECK_EN
        #1;
        checkOutput("range_err", err, 1);
        checkOutput("range_code", errCode, 2'b10);
        checkOutput("range_count", errCount, 2);
`else
        expectWord("ADDI200", 16'h53C8, 10'h015);
`endif
        cycle();
        drain();

        $display("[TB] backpressure");
        sent = 0;
        for (int c = 0; c < 40 && sent < 6; c++) begin
            memReady = (c >= 8);
            applyStimulus(1'b1, 8'(16 * (sent + 1)), 4'(sent), 4'(sent + 3), 16'(sent * 7));
            if (c == 7) begin
                #1;
                checkOutput("stall_ready_low", inReady, 0);
                checkOutput("stall_valid_high", memValid, 1);
            end
            cycle();
            if (lastAccepted) sent++;
        end
        inValid = 1'b0;
        checkOutput("bp_all_sent", sent, 6);
        drain();

        $display("[TB] random traffic");
        for (int c = 0; c < 300; c++) begin
            int r;
            r = int'($urandom_range(0, 40)) - 20;
            applyStimulus(1'($urandom_range(0, 1)), 8'($urandom), 4'($urandom), 4'($urandom),
                          ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'(r));
            memReady = ($urandom_range(0, 3) != 0);
            cycle();
        end
        inValid  = 1'b0;
        memReady = 1'b1;
        drain();

        $display("[TB] reset mid-session");
        memReady = 1'b0;
        sendBundle(8'h10, 4'd1, 4'd0, 16'd1);
        sendBundle(8'h20, 4'd2, 4'd0, 16'd2);
        sendBundle(8'h30, 4'd3, 4'd0, 16'd3);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        #1;
        checkOutput("midrst_mem_valid", memValid, 0);
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_err_count", errCount, 0);
        memReady = 1'b1;
        repeat (3) cycle();

        $display("[TB] address exhaustion");
        startAddr = 10'h3FE;
        start     = 1'b1;
        cycle();
        start = 1'b0;
        sendBundle(8'h10, 4'd5, 4'd0, 16'd9);
        sendBundle(8'h04, 4'd6, 4'd8, 16'd0);
        applyStimulus(1'b1, 8'h20, 4'd7, 4'd0, 16'd1);
        for (int c = 0; c < 6; c++) cycle();
        #1;
        checkOutput("exhaust_ready_low", inReady, 0);
        checkOutput("exhaust_done", done, 1);
        checkOutput("exhaust_busy", busy, 0);
        inValid   = 1'b0;
        startAddr = 10'h020;
        start     = 1'b1;
        cycle();
        start = 1'b0;
        sendBundle(8'h40, 4'd1, 4'd7, 16'h0000);
        expectWord("restart", 16'h4107, 10'h020);
        cycle();
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
